// File: rtl/pc_fetch.sv
// pc_fetch: PC register and req/ack instruction fetch sequencer; define FETCH_CNT_EN to count accepted instructions on fetch_cnt
module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] newpc,
  output logic [29:0] pcout,
  output logic        im_req,
  output logic [29:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        im_err,
  output logic [31:0] fetch_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERR} state_t;
  state_t state, state_nxt;
  logic [15:0] timer;
  logic ack_edge, accept, tmo;
  assign ack_edge    = state == FETCH && im_ack;
  assign accept      = state == VALID && instr_ready;
  assign tmo         = state == FETCH && !im_ack && timer == 16'(TIMEOUT - 1);
  assign im_req      = state == FETCH;
  assign instr_valid = state == VALID;
  assign im_err      = state == ERR;
  assign im_addr     = pcout;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? FETCH : ack_edge ? VALID : tmo ? ERR : accept ? FETCH : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcout <= RESET_PC;
      instr <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (ack_edge) begin
        instr <= im_rdata;
        timer <= '0;
      end else if (state == FETCH) begin
        timer <= timer + 16'd1;
      end
      if (accept) pcout <= newpc;
    end
  end
`ifdef FETCH_CNT_EN
  always_ff @(posedge clk) fetch_cnt <= rst ? '0 : fetch_cnt + 32'(accept);
`else
  assign fetch_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized fetch/accept sequences checked against a PC/count model
module tb_pc_fetch;
  logic        clk = 0, rst = 1;
  logic [29:0] newpc = '0;
  logic [29:0] pcout, im_addr;
  logic        im_req, im_ack = 0, instr_valid, instr_ready = 0, im_err;
  logic [31:0] im_rdata = '0, instr, fetch_cnt;
  int checks = 0, errors = 0, cnt = 0;
  logic [29:0] pc;
  always #5 clk = ~clk;
  pc_fetch dut (
    .clk(clk), .rst(rst), .newpc(newpc), .pcout(pcout), .im_req(im_req),
    .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .im_err(im_err),
    .fetch_cnt(fetch_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] exp_cnt(input int c);
`ifdef FETCH_CNT_EN
    return 32'(c);
`else
    return 32'(0) & 32'(c);
`endif
  endfunction
  task automatic fetch_one(input logic [29:0] a, input logic [31:0] d, input int dly, input int stall, input logic [29:0] nxt);
    chk("req", 32'(im_req), 1);
    chk("addr", 32'(im_addr), 32'(a));
    for (int i = 0; i < dly; i++) begin
      im_ack = 0;
      instr_ready = 1'($urandom);
      step;
      chk("wait_req", 32'(im_req), 1);
      chk("wait_err", 32'(im_err), 0);
    end
    im_ack = 1;
    im_rdata = d;
    step;
    im_ack = 0;
    im_rdata = $urandom;
    chk("valid", 32'(instr_valid), 1);
    chk("instr", instr, d);
    chk("req_off", 32'(im_req), 0);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 0;
      newpc = 30'($urandom);
      step;
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", instr, d);
      chk("stall_pc", 32'(pcout), 32'(a));
    end
    newpc = nxt;
    instr_ready = 1;
    step;
    instr_ready = 0;
    newpc = 30'($urandom);
    cnt++;
    chk("next_pc", 32'(pcout), 32'(nxt));
    chk("next_addr", 32'(im_addr), 32'(nxt));
    chk("valid_off", 32'(instr_valid), 0);
    chk("cnt", fetch_cnt, exp_cnt(cnt));
  endtask
  initial begin
    step;
    step;
    chk("rst_pc", 32'(pcout), 32'h0C00);
    chk("rst_req", 32'(im_req), 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_err", 32'(im_err), 0);
    chk("rst_cnt", fetch_cnt, 0);
    rst = 0;
    step;
    pc = 30'h0C00;
    for (int k = 1; k <= 4; k++) begin
      fetch_one(pc, 32'h2408_0000 + 32'(k), 0, 0, pc + 30'd1);
      pc = pc + 30'd1;
    end
    fetch_one(pc, 32'h1234_5678, 2, 5, 30'h0D00);
    fetch_one(30'h0D00, 32'hCAFE_0001, 0, 0, 30'h0123_4567);
    fetch_one(30'h0123_4567, 32'h0800_0000, 0, 0, 30'h3FFF_FFFF);
    fetch_one(30'h3FFF_FFFF, 32'hAAAA_5555, 15, 1, 30'h3FFF_FFFF + 30'd1);
    pc = '0;
    for (int k = 0; k < 30; k++) begin
      logic [29:0] nxt;
      nxt = $urandom_range(0, 1) == 1 ? pc + 30'd1 : 30'($urandom);
      fetch_one(pc, $urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), nxt);
      pc = nxt;
    end
    instr_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      im_ack = 0;
      step;
      chk("tmo_req", 32'(im_req), i < 16 ? 1 : 0);
      chk("tmo_err", 32'(im_err), i == 16 ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      im_ack = 1;
      im_rdata = $urandom;
      instr_ready = 1;
      step;
      chk("err_sticky", 32'(im_err), 1);
      chk("err_req", 32'(im_req), 0);
      chk("err_valid", 32'(instr_valid), 0);
      chk("err_pc", 32'(pcout), 32'(pc));
    end
    im_ack = 0;
    instr_ready = 0;
    rst = 1;
    step;
    cnt = 0;
    chk("clr_err", 32'(im_err), 0);
    chk("clr_pc", 32'(pcout), 32'h0C00);
    chk("clr_cnt", fetch_cnt, 0);
    rst = 0;
    step;
    chk("mid_req_on", 32'(im_req), 1);
    rst = 1;
    step;
    chk("mid_req_off", 32'(im_req), 0);
    chk("mid_valid", 32'(instr_valid), 0);
    rst = 0;
    im_ack = 1;
    im_rdata = 32'hDEAD_BEEF;
    step;
    im_ack = 0;
    chk("stray_instr", instr, 0);
    chk("stray_valid", 32'(instr_valid), 0);
    fetch_one(30'h0C00, 32'h0000_0BAD, 1, 0, 30'h0C01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
